// File: rtl/ann_weight_pkg.sv
// Shared types and helpers for the ANN weight streaming blocks.
// Holds the default weight width, the streamer FSM encoding and the wrapping address step.
package ann_weight_pkg;

  localparam int WEIGHT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN,
    FINISH
  } ws_state_t;

  function automatic int unsigned ws_wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr + 1 >= depth) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO with occupancy count; head word drives the output and holds while stalled.
// Zero-latency output from head; push is refused only when full and no pop is happening.
module weight_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    pop      = (cnt_q != 2'd0) && pop_rdy;
    push     = push_vld && ((cnt_q != 2'd2) || pop);
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      slot_d[wr_ptr_q] = push_dat;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    pop_vld = (cnt_q != 2'd0);
    pop_dat = slot_q[rd_ptr_q];
    count   = cnt_q;
  end

endmodule

// File: rtl/weight_stream_bram.sv
// Block-RAM weight store with a load port and a self-sequenced burst reader (wraps modulo DEPTH).
// First word valid two cycles after START; reads are throttled by FIFO credit so DO_READY stalls never drop data.
module weight_stream_bram
  import ann_weight_pkg::*;
#(
  parameter int    WIDTH     = WEIGHT_W,
  parameter int    DEPTH     = 28,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [WIDTH-1:0]  DO,
  output logic              DO_VALID,
  input  logic              DO_READY
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  ws_state_t         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   rd_left_q, rd_left_d;
  logic [ADDR_W:0]   xfer_left_q, xfer_left_d;
  logic              rd_vld_q, rd_vld_d;
  logic [WIDTH-1:0]  rd_dat_q;

  logic              wr_ok;
  logic              rd_en;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;

  // Credit counts the head word leaving this cycle, so full-rate streaming never bubbles.
  always_comb begin
    wr_ok = WR_EN && (32'(WR_ADDR) < DEPTH);
    pop   = DO_VALID && DO_READY;
    occ   = 3'(rd_vld_q) + 3'(fifo_cnt) - 3'(pop);
    rd_en = (state_q == BURST) && (occ < 3'd2);
  end

  // Two independent ports; non-blocking update gives read-first on a same-address collision.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[WR_ADDR] <= WR_DATA;
    end
    if (rd_en) begin
      rd_dat_q <= mem[rd_addr_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      xfer_left_q <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      xfer_left_q <= xfer_left_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    xfer_left_d = xfer_left_q;
    rd_vld_d    = rd_en;
    if (pop) begin
      xfer_left_d = xfer_left_q - 1'b1;
    end
    if (rd_en) begin
      rd_addr_d = ADDR_W'(ws_wrap_inc(32'(rd_addr_q), DEPTH));
      rd_left_d = rd_left_q - 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (START) begin
          rd_addr_d   = BASE;
          rd_left_d   = LEN;
          xfer_left_d = LEN;
          // An empty burst passes through DRAIN, which completes at once, so DONE lands one cycle later.
          state_d     = (LEN == '0) ? DRAIN : BURST;
        end
      end
      BURST: begin
        if (rd_en && (rd_left_q == 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((xfer_left_q == '0) || ((xfer_left_q == 1) && pop)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    BUSY = (state_q == BURST) || (state_q == DRAIN);
    DONE = (state_q == FINISH);
  end

  weight_skid_fifo #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_vld(rd_vld_q),
    .push_dat(rd_dat_q),
    .pop_rdy (DO_READY),
    .pop_vld (DO_VALID),
    .pop_dat (DO),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_weight_stream_bram.sv
// Directed and randomized bursts against an array/queue model of the weight store.
module tb_weight_stream_bram;

  localparam int DEPTH = 28;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WR_EN;
  logic [4:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic        START;
  logic [4:0]  BASE;
  logic [5:0]  LEN;
  logic        BUSY;
  logic        DONE;
  logic [15:0] DO;
  logic        DO_VALID;
  logic        DO_READY;

  int errors = 0;
  int checks = 0;
  logic [15:0] ref_mem [DEPTH];

  always #5 CLK = ~CLK;

  weight_stream_bram dut (
    .CLK     (CLK),
    .RST     (RST),
    .WR_EN   (WR_EN),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .START   (START),
    .BASE    (BASE),
    .LEN     (LEN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .DO      (DO),
    .DO_VALID(DO_VALID),
    .DO_READY(DO_READY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    WR_EN   = 1'b1;
    WR_ADDR = 5'(a);
    WR_DATA = d;
    step();
    WR_EN   = 1'b0;
    if (a < DEPTH) ref_mem[a] = d;
  endtask

  // Runs one burst from a post-edge point; optional mid-burst write, stray START, or reset abort.
  task automatic run_burst(input int base, input int len, input int rdy_pct,
                           input int wr_cyc, input int wr_a, input logic [15:0] wr_val,
                           input bit poke_start, input int abort_word);
    int exp_q[$];
    int cyc, got_n, first_vld, done_cyc;
    bit rdy, prev_stall;
    logic [15:0] prev_dat;
    for (int i = 0; i < len; i++) exp_q.push_back(int'(ref_mem[(base + i) % DEPTH]));
    START = 1'b1;
    BASE  = 5'(base);
    LEN   = 6'(len);
    step();
    START = 1'b0;
    cyc = 0; got_n = 0; first_vld = -1; done_cyc = -1; prev_stall = 1'b0; prev_dat = '0;
    check("busy_after_start", 32'(BUSY), 1);
    while (cyc < 300) begin
      if (cyc == wr_cyc) begin
        WR_EN = 1'b1; WR_ADDR = 5'(wr_a); WR_DATA = wr_val;
      end else begin
        WR_EN = 1'b0;
      end
      if (poke_start && cyc == 3) begin
        START = 1'b1; BASE = 5'($urandom_range(DEPTH - 1)); LEN = 6'($urandom_range(DEPTH, 1));
      end else begin
        START = 1'b0;
      end
      if (DONE) done_cyc = cyc;
      else check("busy_during", 32'(BUSY), 1);
      if (DO_VALID && first_vld < 0) first_vld = cyc;
      if (prev_stall) begin
        check("hold_vld", 32'(DO_VALID), 1);
        check("hold_dat", 32'(DO), 32'(prev_dat));
      end
      rdy = ($urandom_range(99) < rdy_pct);
      DO_READY = rdy;
      if (DO_VALID && rdy) begin
        if (got_n == abort_word) begin
          WR_EN = 1'b0; START = 1'b0; RST = 1'b1;
          step();
          RST = 1'b0;
          check("abort_vld", 32'(DO_VALID), 0);
          check("abort_do", 32'(DO), 0);
          check("abort_busy", 32'(BUSY), 0);
          for (int i = 0; i < 6; i++) begin
            check("abort_no_done", 32'(DONE), 0);
            step();
          end
          return;
        end
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else check("word", 32'(DO), 32'(exp_q.pop_front()));
        got_n++;
      end
      prev_stall = DO_VALID && !rdy;
      prev_dat   = DO;
      if (done_cyc >= 0) break;
      step();
      cyc++;
    end
    WR_EN = 1'b0;
    START = 1'b0;
    if (done_cyc < 0) check("done_timeout", 0, 1);
    check("word_count", got_n, len);
    check("first_vld_cyc", first_vld, (len == 0) ? -1 : 2);
    if (rdy_pct >= 100) check("done_cyc", done_cyc, (len == 0) ? 1 : len + 2);
    step();
    check("done_single", 32'(DONE), 0);
    check("idle_busy", 32'(BUSY), 0);
    check("idle_vld", 32'(DO_VALID), 0);
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    START = 1'b0; BASE = '0; LEN = '0; DO_READY = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_vld", 32'(DO_VALID), 0);
    check("rst_do", 32'(DO), 0);
    RST = 1'b0;
    step();

    for (int a = 0; a < DEPTH; a++) write_word(a, 16'(a));
    write_word(30, 16'hDEAD);
    write_word(31, 16'hDEAD);

    run_burst(0, 28, 100, -1, 0, '0, 1'b0, -1);
    run_burst(25, 6, 100, -1, 0, '0, 1'b0, -1);
    run_burst(0, 10, 50, -1, 0, '0, 1'b1, -1);
    run_burst(0, 0, 100, -1, 0, '0, 1'b0, -1);

    run_burst(0, 28, 100, 5, 5, 16'hBEEF, 1'b0, -1);
    ref_mem[5] = 16'hBEEF;
    run_burst(2, 8, 100, -1, 0, '0, 1'b0, -1);

    run_burst(0, 10, 100, -1, 0, '0, 1'b0, 3);
    run_burst(20, 12, 100, -1, 0, '0, 1'b0, -1);

    for (int n = 0; n < 5; n++) begin
      for (int w = 0; w < 3; w++) write_word($urandom_range(DEPTH - 1), 16'($urandom));
      run_burst($urandom_range(DEPTH - 1), $urandom_range(DEPTH, 1), 60, -1, 0, '0, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
